// File: rtl/if_pkg.sv
// Shared constants and entry layout for the instruction-fetch prefetch buffer.
package if_pkg;
  localparam int          WORD_W    = 32;
  localparam logic [31:0] PC_INC    = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_entry_t;
endpackage

// File: rtl/if_buf_ram.sv
// Entry storage for the prefetch buffer: one synchronous write port, one combinational read port.
module if_buf_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/if_prefetch_buf.sv
// Prefetch FIFO between the PC register and IF/ID: gates PC advance on space and
// drops everything on a redirect flush.
module if_prefetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] instr_in,
  input  logic              fetch_vld,
  input  logic              flush,
  output logic              pc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_pc4,
  output logic [WORD_W-1:0] out_instr,
  output logic [CNT_W-1:0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [2*WORD_W-1:0] rd_data;
  logic                full, push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready & ~flush;
  // Out_ready only matters when full: a simultaneous pop frees the slot being written.
  assign push      = fetch_vld & ~flush & (~full | pop);
  assign pc_en     = flush | push;

  if_buf_ram #(.DEPTH(DEPTH), .W(2*WORD_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({pc_in, instr_in}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign out_pc    = rd_data[2*WORD_W-1:WORD_W];
  assign out_instr = rd_data[WORD_W-1:0];
  assign out_pc4   = out_pc + WORD_W'(PC_INC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf: fill/drain, full push+pop, flush, wrap, async reset.
module tb_if_prefetch_buf;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instr_in;
  logic        fetch_vld, flush, out_ready;
  logic        pc_en, out_valid;
  logic [31:0] out_pc, out_pc4, out_instr;
  logic [2:0]  count;

  int errs = 0;
  int chks = 0;

  if_prefetch_buf dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .fetch_vld (fetch_vld),
    .flush     (flush),
    .pc_en     (pc_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge to sample and drive.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    fetch_vld = 1'b1; out_ready = 1'b1;
    pc_in = 32'h0040_0000; instr_in = 32'h2008_0005;
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pc4", out_pc4, 32'd4);
    chk("rst_pcen", {31'd0, pc_en}, 32'd1);

    // 1: first fetch appears next cycle
    @(negedge clk); rst = 1'b1;
    tick;
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_pc", out_pc, 32'h0040_0000);
    chk("t1_pc4", out_pc4, 32'h0040_0004);
    chk("t1_instr", out_instr, 32'h2008_0005);
    chk("t1_count", {29'd0, count}, 32'd1);
    fetch_vld = 1'b0;
    tick;
    chk("t1_drain", {29'd0, count}, 32'd0);

    // 2: fill to full with out_ready low
    out_ready = 1'b0; fetch_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = 32'(i*4); instr_in = 32'hA000_0000 | 32'(i*4);
      tick;
    end
    chk("t2_count", {29'd0, count}, 32'd4);
    pc_in = 32'h10; instr_in = 32'hA000_0010;
    #1;
    chk("t2_pcen_full", {31'd0, pc_en}, 32'd0);
    tick;
    chk("t2_count_hold", {29'd0, count}, 32'd4);
    chk("t2_head", out_pc, 32'h0);

    // 3: full with simultaneous pop and push
    out_ready = 1'b1;
    #1;
    chk("t3_pcen", {31'd0, pc_en}, 32'd1);
    tick;
    chk("t3_count", {29'd0, count}, 32'd4);
    chk("t3_head", out_pc, 32'h4);
    fetch_vld = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk("t23_order_pc", out_pc, 32'(i*4));
      chk("t23_order_instr", out_instr, 32'hA000_0000 | 32'(i*4));
      tick;
    end
    chk("t23_empty", {31'd0, out_valid}, 32'd0);

    // 4: flush with three entries, ready and fetch both high
    out_ready = 1'b0; fetch_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'h100 + 32'(i*4);
      tick;
    end
    chk("t4_count3", {29'd0, count}, 32'd3);
    flush = 1'b1; out_ready = 1'b1; pc_in = 32'h10C;
    #1;
    chk("t4_pcen", {31'd0, pc_en}, 32'd1);
    tick;
    flush = 1'b0;
    chk("t4_count", {29'd0, count}, 32'd0);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);

    // 5: +4 wraps at top of address space, then pointer wrap under streaming
    out_ready = 1'b0; fetch_vld = 1'b1;
    pc_in = 32'hFFFF_FFFC; instr_in = 32'h1234_5678;
    tick;
    chk("t5_pc", out_pc, 32'hFFFF_FFFC);
    chk("t5_pc4", out_pc4, 32'h0000_0000);
    fetch_vld = 1'b0; out_ready = 1'b1;
    tick;
    fetch_vld = 1'b1;
    pc_in = 32'h200; instr_in = 32'hB000_0200;
    tick;
    for (int k = 1; k <= 9; k++) begin
      chk("t5_stream_pc", out_pc, 32'h200 + 32'((k-1)*4));
      chk("t5_stream_instr", out_instr, 32'hB000_0200 + 32'((k-1)*4));
      chk("t5_stream_cnt", {29'd0, count}, 32'd1);
      pc_in = 32'h200 + 32'(k*4); instr_in = 32'hB000_0200 + 32'(k*4);
      tick;
    end
    fetch_vld = 1'b0;
    chk("t5_last", out_pc, 32'h224);
    tick;
    chk("t5_empty", {29'd0, count}, 32'd0);

    // 6: async reset between edges drops entries
    out_ready = 1'b0; fetch_vld = 1'b1;
    pc_in = 32'h280; tick;
    pc_in = 32'h284; tick;
    chk("t6_count2", {29'd0, count}, 32'd2);
    fetch_vld = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    rst = 1'b1; fetch_vld = 1'b1; pc_in = 32'h300; instr_in = 32'hC000_0300;
    #1;
    chk("t6_no_bypass", {31'd0, out_valid}, 32'd0);
    tick;
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pc", out_pc, 32'h300);
    chk("t6_instr", out_instr, 32'hC000_0300);
    chk("t6_count", {29'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
